// File: rtl/memacc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memacc_pkg: shared types and lane helpers for the MEM-stage access   |
// | controller.                                 Revision: 1.0            |
// +----------------------------------------------------------------------+
package memacc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RREQ  = 3'd1,
    ST_RDATA = 3'd2,
    ST_WREQ  = 3'd3,
    ST_WACK  = 3'd4
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_B:    be_gen = 4'b0001 << a;
      SZ_H:    be_gen = 4'b0011 << {a[1], 1'b0};
      SZ_W:    be_gen = 4'hF;
      default: be_gen = 4'h0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_B:    is_legal = 1'b1;
      SZ_H:    is_legal = ~a[0];
      SZ_W:    is_legal = (a == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  // Input is already shifted down so the addressed byte sits in lane 0.
  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] size,
                                              input logic uns);
    case (size)
      SZ_B:    load_extend = uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      SZ_H:    load_extend = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: load_extend = d;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/memacc_lsu_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memacc_lsu_fmt: byte-enable / store lane shift and load extraction.  |
// |                                             Revision: 1.0            |
// +----------------------------------------------------------------------+
module memacc_lsu_fmt
  import memacc_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_sh,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  always_comb begin
    st_be       = be_gen(st_size, st_addr_lo);
    st_wdata_sh = st_wdata << {st_addr_lo, 3'b000};
    ld_data     = load_extend(ld_rdata >> {ld_addr_lo, 3'b000}, ld_size, ld_unsigned);
  end

endmodule
`default_nettype wire

// File: rtl/memacc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memacc_ctrl: one-outstanding data-RAM access sequencer with posted   |
// | stores and pipeline stall generation.       Revision: 1.0            |
// +----------------------------------------------------------------------+
module memacc_ctrl
  import memacc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        exe_load,
  input  logic        exe_store,
  input  logic [31:0] exe_addr,
  input  logic [1:0]  exe_size,
  input  logic        exe_unsigned,
  input  logic [31:0] exe_wdata,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic        ram_gnt,
  input  logic        ram_rvalid,
  input  logic [31:0] ram_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        mem_stall,
  output logic        readram_stall,
  output logic        exe_store_load_conflict,
  output logic        misalign,
  output logic        bus_fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               load_valid_q, load_valid_d;
  logic               misalign_q, misalign_d;
  logic               bus_fault_q, bus_fault_d;

  logic [3:0]         fmt_be;
  logic [31:0]        fmt_wdata;
  logic [31:0]        fmt_ld_data;
  logic               timed_out;
  logic               store_side;

  memacc_lsu_fmt u_fmt (
    .st_addr_lo  (exe_addr[1:0]),
    .st_size     (exe_size),
    .st_wdata    (exe_wdata),
    .st_be       (fmt_be),
    .st_wdata_sh (fmt_wdata),
    .ld_addr_lo  (addr_q[1:0]),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_rdata    (ram_rdata),
    .ld_data     (fmt_ld_data)
  );

  always_ff @(posedge clk) begin
    if (cpurst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      bus_fault_q  <= bus_fault_d;
    end
  end

  // Valid has priority over the timeout when both land on the same cycle.
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    load_data_d  = '0;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    bus_fault_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exe_store || exe_load) begin
          if (!is_legal(exe_size, exe_addr[1:0])) begin
            misalign_d = 1'b1;
          end else begin
            addr_d  = exe_addr;
            size_d  = exe_size;
            uns_d   = exe_unsigned;
            be_d    = fmt_be;
            wdata_d = fmt_wdata;
            state_d = exe_store ? ST_WREQ : ST_RREQ;
          end
        end
      end
      ST_RREQ: begin
        if (ram_gnt) begin
          state_d = ST_RDATA;
          cnt_d   = '0;
        end
      end
      ST_WREQ: begin
        if (ram_gnt) begin
          state_d = ST_WACK;
          cnt_d   = '0;
        end
      end
      ST_RDATA: begin
        if (ram_rvalid) begin
          load_valid_d = 1'b1;
          load_data_d  = fmt_ld_data;
          state_d      = ST_IDLE;
        end else if (timed_out) begin
          load_valid_d = 1'b1;
          bus_fault_d  = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WACK: begin
        if (ram_rvalid) begin
          state_d = ST_IDLE;
        end else if (timed_out) begin
          bus_fault_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    store_side              = (state_q == ST_WREQ) || (state_q == ST_WACK);
    ram_req                 = (state_q == ST_RREQ) || (state_q == ST_WREQ);
    ram_we                  = (state_q == ST_WREQ);
    ram_addr                = ram_req ? {addr_q[31:2], 2'b00} : '0;
    ram_be                  = ram_req ? be_q : '0;
    ram_wdata               = ram_we ? wdata_q : '0;
    readram_stall           = (state_q == ST_RREQ) || (state_q == ST_RDATA);
    // A simultaneous store decodes as a store, so it never counts as a conflicting load.
    exe_store_load_conflict = store_side && exe_load && !exe_store &&
                              (exe_addr[31:2] == addr_q[31:2]);
    mem_stall               = store_side && (exe_store || (exe_load && !exe_store_load_conflict));
    load_data               = load_data_q;
    load_valid              = load_valid_q;
    misalign                = misalign_q;
    bus_fault               = bus_fault_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_memacc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memacc_ctrl: directed vector table plus multi-cycle sequences.    |
// |                                             Revision: 1.0            |
// +----------------------------------------------------------------------+
module tb_memacc_ctrl;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        exe_load, exe_store, exe_unsigned;
  logic [31:0] exe_addr, exe_wdata;
  logic [1:0]  exe_size;
  logic        ram_req, ram_we, ram_gnt, ram_rvalid;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, load_data;
  logic [3:0]  ram_be;
  logic        load_valid, mem_stall, readram_stall, exe_store_load_conflict;
  logic        misalign, bus_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memacc_ctrl #(.TIMEOUT(15)) dut (
    .clk                     (clk),
    .cpurst                  (cpurst),
    .exe_load                (exe_load),
    .exe_store               (exe_store),
    .exe_addr                (exe_addr),
    .exe_size                (exe_size),
    .exe_unsigned            (exe_unsigned),
    .exe_wdata               (exe_wdata),
    .ram_req                 (ram_req),
    .ram_we                  (ram_we),
    .ram_addr                (ram_addr),
    .ram_be                  (ram_be),
    .ram_wdata               (ram_wdata),
    .ram_gnt                 (ram_gnt),
    .ram_rvalid              (ram_rvalid),
    .ram_rdata               (ram_rdata),
    .load_data               (load_data),
    .load_valid              (load_valid),
    .mem_stall               (mem_stall),
    .readram_stall           (readram_stall),
    .exe_store_load_conflict (exe_store_load_conflict),
    .misalign                (misalign),
    .bus_fault               (bus_fault)
  );

  typedef struct packed {
    logic        st;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic quiet_exe();
    exe_load = 1'b0; exe_store = 1'b0; exe_unsigned = 1'b0;
    exe_addr = '0; exe_size = 2'd0; exe_wdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_we"}, {30'd0, ram_req, ram_we}, 32'd0);
    chk({tag, "_addr"}, ram_addr, 32'd0);
    chk({tag, "_be"}, {28'd0, ram_be}, 32'd0);
    chk({tag, "_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_ldata"}, load_data, 32'd0);
    chk({tag, "_pulses"}, {29'd0, load_valid, misalign, bus_fault}, 32'd0);
    chk({tag, "_stalls"}, {29'd0, mem_stall, readram_stall, exe_store_load_conflict}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          st    addr          sz    u     wdata         rdata         mis   be       exp_wdata     exp_ld
    vecs[0]  = '{1'b0, 32'h0000_1003, 2'd0, 1'b0, 32'h0,        32'h80FF_FF11, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 32'h0000_1001, 2'd0, 1'b1, 32'h0,        32'h80FF_FF11, 1'b0, 4'b0010, 32'h0,        32'h0000_00FF};
    vecs[2]  = '{1'b0, 32'h0000_1002, 2'd1, 1'b0, 32'h0,        32'h80FF_FF11, 1'b0, 4'b1100, 32'h0,        32'hFFFF_80FF};
    vecs[3]  = '{1'b0, 32'h0000_1000, 2'd1, 1'b1, 32'h0,        32'h80FF_FF11, 1'b0, 4'b0011, 32'h0,        32'h0000_FF11};
    vecs[4]  = '{1'b0, 32'h0000_1004, 2'd2, 1'b0, 32'h0,        32'h1234_5678, 1'b0, 4'b1111, 32'h0,        32'h1234_5678};
    vecs[5]  = '{1'b0, 32'h0000_1000, 2'd1, 1'b0, 32'h0,        32'h0000_7FFF, 1'b0, 4'b0011, 32'h0,        32'h0000_7FFF};
    vecs[6]  = '{1'b1, 32'h0000_2001, 2'd0, 1'b0, 32'h1234_56A5, 32'h0,        1'b0, 4'b0010, 32'h3456_A500, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_2008, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_ABCD, 32'h0,        1'b0, 4'b1100, 32'hABCD_0000, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_4001, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 32'h0000_4003, 2'd1, 1'b0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 32'h0000_4000, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 32'h0000_2001, 2'd1, 1'b0, 32'h0000_1111, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};

    quiet_exe();
    cpurst = 1'b1; ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0;
    cyc(); cyc();
    #1 chk_all_zero("reset");
    cpurst = 1'b0;

    // Table: single transactions with immediate grant and valid.
    for (int i = 0; i < NV; i++) begin
      cyc();
      exe_load = ~vecs[i].st; exe_store = vecs[i].st; exe_addr = vecs[i].addr;
      exe_size = vecs[i].size; exe_unsigned = vecs[i].uns; exe_wdata = vecs[i].wdata;
      #1 chk($sformatf("v%0d_idle_stalls", i), {29'd0, mem_stall, readram_stall, exe_store_load_conflict}, 32'd0);
      cyc();
      quiet_exe();
      #1;
      if (vecs[i].mis) begin
        chk($sformatf("v%0d_misalign", i), {31'd0, misalign}, 32'd1);
        chk($sformatf("v%0d_mis_req", i), {31'd0, ram_req}, 32'd0);
        cyc(); #1;
        chk($sformatf("v%0d_mis_pulse_end", i), {31'd0, misalign}, 32'd0);
        chk($sformatf("v%0d_mis_idle", i), {30'd0, ram_req, readram_stall}, 32'd0);
      end else begin
        chk($sformatf("v%0d_req_we", i), {30'd0, ram_req, ram_we}, {30'd0, 1'b1, vecs[i].st});
        chk($sformatf("v%0d_addr", i), ram_addr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_be", i), {28'd0, ram_be}, {28'd0, vecs[i].be});
        chk($sformatf("v%0d_wdata", i), ram_wdata, vecs[i].exp_wdata);
        chk($sformatf("v%0d_rstall1", i), {31'd0, readram_stall}, {31'd0, ~vecs[i].st});
        ram_gnt = 1'b1;
        cyc();
        ram_gnt = 1'b0; ram_rvalid = 1'b1; ram_rdata = vecs[i].rdata;
        #1 chk($sformatf("v%0d_req_drop", i), {31'd0, ram_req}, 32'd0);
        chk($sformatf("v%0d_rstall2", i), {31'd0, readram_stall}, {31'd0, ~vecs[i].st});
        chk($sformatf("v%0d_early_valid", i), {31'd0, load_valid}, 32'd0);
        cyc();
        ram_rvalid = 1'b0; ram_rdata = '0;
        #1 chk($sformatf("v%0d_lvalid", i), {31'd0, load_valid}, {31'd0, ~vecs[i].st});
        if (!vecs[i].st) chk($sformatf("v%0d_ldata", i), load_data, vecs[i].exp_ld);
        chk($sformatf("v%0d_done_stall", i), {30'd0, readram_stall, mem_stall}, 32'd0);
      end
    end

    // Store half with a 3-cycle grant delay, and a second store held behind it.
    cyc();
    exe_store = 1'b1; exe_addr = 32'h2002; exe_size = 2'd1; exe_wdata = 32'h0000_ABCD;
    #1 chk("sA_accept_stall", {31'd0, mem_stall}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      exe_store = 1'b1; exe_addr = 32'h2100; exe_size = 2'd2; exe_wdata = 32'h1122_3344;
      #1 chk($sformatf("sA_hold%0d_req", k), {30'd0, ram_req, ram_we}, 32'd3);
      chk($sformatf("sA_hold%0d_addr", k), ram_addr, 32'h2000);
      chk($sformatf("sA_hold%0d_be", k), {28'd0, ram_be}, 32'hC);
      chk($sformatf("sA_hold%0d_wdata", k), ram_wdata, 32'hABCD_0000);
      chk($sformatf("sA_hold%0d_mstall", k), {31'd0, mem_stall}, 32'd1);
    end
    cyc(); ram_gnt = 1'b1;
    #1 chk("sA_gnt_req", {31'd0, ram_req}, 32'd1);
    cyc(); ram_gnt = 1'b0;
    #1 chk("sA_wack_req", {31'd0, ram_req}, 32'd0);
    chk("sA_wack_mstall", {31'd0, mem_stall}, 32'd1);
    ram_rvalid = 1'b1;
    cyc(); ram_rvalid = 1'b0;
    #1 chk("sA_idle_mstall", {31'd0, mem_stall}, 32'd0);
    cyc(); quiet_exe();
    #1 chk("sA_2nd_req", {30'd0, ram_req, ram_we}, 32'd3);
    chk("sA_2nd_addr", ram_addr, 32'h2100);
    chk("sA_2nd_wdata", ram_wdata, 32'h1122_3344);
    ram_gnt = 1'b1;
    cyc(); ram_gnt = 1'b0; ram_rvalid = 1'b1;
    cyc(); ram_rvalid = 1'b0;

    // Store to 0x3000 then a load to the same word while the store is in WACK.
    cyc();
    exe_store = 1'b1; exe_addr = 32'h3000; exe_size = 2'd2; exe_wdata = 32'h5555_AAAA;
    cyc(); quiet_exe(); ram_gnt = 1'b1;
    cyc(); ram_gnt = 1'b0;
    exe_load = 1'b1; exe_addr = 32'h3002; exe_size = 2'd1; exe_unsigned = 1'b0;
    #1 chk("sB_conflict", {31'd0, exe_store_load_conflict}, 32'd1);
    chk("sB_no_mstall", {30'd0, mem_stall, readram_stall}, 32'd0);
    exe_addr = 32'h3004;
    #1 chk("sB_other_word_mstall", {31'd0, mem_stall}, 32'd1);
    chk("sB_other_word_conf", {31'd0, exe_store_load_conflict}, 32'd0);
    exe_addr = 32'h3002;
    cyc(); ram_rvalid = 1'b1;
    #1 chk("sB_conflict_ack", {31'd0, exe_store_load_conflict}, 32'd1);
    cyc(); ram_rvalid = 1'b0;
    #1 chk("sB_idle_conf", {30'd0, exe_store_load_conflict, mem_stall}, 32'd0);
    cyc(); quiet_exe();
    #1 chk("sB_ld_req", {30'd0, ram_req, ram_we}, 32'd2);
    chk("sB_ld_addr", ram_addr, 32'h3000);
    chk("sB_ld_be", {28'd0, ram_be}, 32'hC);
    chk("sB_ld_rstall", {31'd0, readram_stall}, 32'd1);
    ram_gnt = 1'b1;
    cyc(); ram_gnt = 1'b0; ram_rvalid = 1'b1; ram_rdata = 32'hBEEF_0000;
    cyc(); ram_rvalid = 1'b0; ram_rdata = '0;
    #1 chk("sB_ld_valid", {31'd0, load_valid}, 32'd1);
    chk("sB_ld_data", load_data, 32'hFFFF_BEEF);

    // Read that never returns data; grant and valid together in RREQ count only as grant.
    cyc();
    exe_load = 1'b1; exe_addr = 32'h5000; exe_size = 2'd2;
    cyc(); quiet_exe(); ram_gnt = 1'b1; ram_rvalid = 1'b1; ram_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 15; k++) begin
      cyc(); ram_gnt = 1'b0; ram_rvalid = 1'b0;
      #1 chk($sformatf("sC_wait%0d_fault", k), {30'd0, bus_fault, load_valid}, 32'd0);
      chk($sformatf("sC_wait%0d_rstall", k), {31'd0, readram_stall}, 32'd1);
    end
    cyc();
    #1 chk("sC_fault", {30'd0, bus_fault, load_valid}, 32'd3);
    chk("sC_fault_data", load_data, 32'd0);
    chk("sC_fault_idle", {31'd0, readram_stall}, 32'd0);
    cyc();
    #1 chk("sC_fault_end", {30'd0, bus_fault, load_valid}, 32'd0);

    // Reset while waiting in RDATA; a late valid must be ignored.
    cyc();
    exe_load = 1'b1; exe_addr = 32'h6000; exe_size = 2'd2;
    cyc(); quiet_exe(); ram_gnt = 1'b1;
    cyc(); ram_gnt = 1'b0; cpurst = 1'b1;
    cyc(); cpurst = 1'b0;
    #1 chk_all_zero("sD_rst");
    ram_rvalid = 1'b1; ram_rdata = 32'h1234_5678;
    cyc(); ram_rvalid = 1'b0; ram_rdata = '0;
    #1 chk("sD_late_valid", {29'd0, load_valid, bus_fault, readram_stall}, 32'd0);
    chk("sD_late_data", load_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memacc_ctrl.md
# memacc_ctrl

Data-memory access controller for the MEM stage. It sequences one outstanding load or store at a time onto the data-RAM request/grant/valid port, formats byte enables and load data, and generates the `mem_stall`, `readram_stall` and `exe_store_load_conflict` controls. The MEM/WB pipeline register consumes these controls to insert NOP bubbles. Stores are posted: the pipeline advances once a store is captured, and a later load to the same word is held off until the store is acknowledged.

## Interface
- `TIMEOUT`, default 15: cycles to wait in `RDATA`/`WACK` before declaring a bus fault.
- `clk` in 1: clock.
- `cpurst` in 1: reset, synchronous, active-high.
- `exe_load`, `exe_store` in 1: MEM-stage access request, mutually exclusive by decode. If both are high, the store wins.
- `exe_addr` in 32: byte address.
- `exe_size` in 2: access size. 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `exe_unsigned` in 1: zero-extend load data.
- `exe_wdata` in 32: store data, right-aligned.
- `ram_req`, `ram_we` out 1: RAM request and write strobe.
- `ram_addr` out 32: word address; bits [1:0] are always 0.
- `ram_be` out 4: byte enables.
- `ram_wdata` out 32: lane-shifted store data.
- `ram_gnt` in 1: request accepted this cycle.
- `ram_rvalid` in 1: read data valid, or write acknowledge.
- `ram_rdata` in 32: read data.
- `load_data` out 32: extended load result, valid with `load_valid`.
- `load_valid` out 1: one-cycle pulse.
- `mem_stall`, `readram_stall`, `exe_store_load_conflict` out 1: pipeline holds.
- `misalign`, `bus_fault` out 1: one-cycle exception pulses.

## Operation
- FSM states: `IDLE`, `RREQ`, `RDATA`, `WREQ`, `WACK`.
- `IDLE` with a legal request: address, size, unsigned flag, be and shifted wdata are captured into registers. Next state is `WREQ` for a store, `RREQ` for a load.
- Byte enables:
  - byte: `be = 4'b0001 << a[1:0]`
  - half: `be = 4'b0011 << {a[1],1'b0}`
  - word: `be = 4'hF`
- Store data is lane-shifted: `ram_wdata = wdata << 8*a[1:0]`.
- Illegal request: a half access with `a[0]=1`, a word access with `a[1:0]!=0`, or size 3.
  - No capture and no RAM access.
  - `misalign` pulses the next cycle.
  - State stays `IDLE`.
- `RREQ`/`WREQ`: `ram_req=1` (`ram_we=1` in `WREQ`) with captured fields. Held until `ram_gnt`, then the state moves to `RDATA`/`WACK`.
- `RDATA` with `ram_rvalid`:
  - `load_data = ram_rdata >> 8*a[1:0]`, then masked to 8/16/32 bits and sign- or zero-extended.
  - `load_valid` pulses and the state returns to `IDLE`.
- `WACK` with `ram_rvalid`: state returns to `IDLE`.
- A wait counter is cleared on entering `RDATA`/`WACK` and increments each cycle there. On reaching `TIMEOUT`, `bus_fault` pulses and the state returns to `IDLE`. In `RDATA` this also pulses `load_valid` with `load_data=0`.
- Stall outputs, all combinational from state and current inputs:
  - `readram_stall = (state==RREQ || state==RDATA)`
  - `exe_store_load_conflict = (state==WREQ || state==WACK) && exe_load && exe_addr[31:2]==cap_addr[31:2]`
  - `mem_stall = (state==WREQ || state==WACK) && (exe_store || (exe_load && !conflict))`
- At most one stall output is high in any cycle.
- While any stall is high, the exe request is not captured and must be held by the pipeline.
- `ram_rvalid` in `IDLE`/`RREQ`/`WREQ` is ignored.

## Timing
- Reset values: state `IDLE`, counter 0. All outputs are 0: `ram_req`, `ram_we`, `ram_addr`, `ram_be`, `ram_wdata`, `load_data`, `load_valid`, `misalign`, `bus_fault`, and all stalls.
- `cpurst` mid-transaction abandons it immediately, with no fault pulse.
- Request accepted at cycle N, then `ram_req` at N+1.
- With `ram_gnt` at N+1 and `ram_rvalid` at N+2, `load_valid` is registered at N+3.
- Minimum load latency is 3 cycles from acceptance. A store occupies the port for at least 2 cycles after acceptance.
- A new request can be accepted in the cycle the state returns to `IDLE`.
- `ram_req` and its fields are stable while `ram_gnt` is low; the request is never withdrawn.
- `ram_gnt` and `ram_rvalid` in the same cycle in `RREQ` count only as the grant. Valid is expected one or more cycles later.
- Timeout and `ram_rvalid` on the same cycle: the valid wins, with no fault.

## Structure
- Shared package `memacc_pkg`:
  - FSM state enum
  - size encodings (`SZ_B`, `SZ_H`, `SZ_W`)
  - a `be_gen` function
  - a `load_extend` function
- One natural sub-module: `memacc_lsu_fmt`, a combinational block for byte-enable and store-data lane shift plus load-data extract and extend. The FSM, counter and stall logic stay in `memacc_ctrl`.
- Target size is about 200 lines of RTL.

## Test plan
- Load byte, `addr=0x1003`, signed, `ram_rdata=0x80FF_FF11`, gnt and rvalid immediate:
  - `ram_addr=0x1000`, `ram_be=4'b1000`
  - `load_valid` 3 cycles after acceptance with `load_data=0xFFFF_FF80`
  - `readram_stall` high for 2 cycles
- Store half, `addr=0x2002`, `wdata=0xABCD`, `ram_gnt` delayed 3 cycles:
  - `ram_be=4'b1100`, `ram_wdata=0xABCD_0000`
  - request held stable
  - a following store sees `mem_stall=1` until the ack
- Store to `0x3000`, then load from `0x3002` while in `WACK`:
  - `exe_store_load_conflict=1`, `mem_stall=0`
  - the load is captured the cycle after `ram_rvalid`
  - a load from `0x3004` instead gives `mem_stall=1`
- Misaligned word load `addr=0x4001`: `misalign` pulse, `ram_req` stays 0, state stays `IDLE`.
- Read with `ram_rvalid` never returned, `TIMEOUT=15`: `bus_fault` and `load_valid` with data 0 after 15 cycles in `RDATA`.
- `cpurst` asserted in `RDATA`: next cycle all outputs are 0 and a late `ram_rvalid` is ignored.
